// File: rtl/md_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_if
//  Description : Execute-stage bundle between the CPU pipeline and the
//                multiply/divide unit (instruction, operands, HI/LO results,
//                busy/stall status).
//  Revision    : 1.0 - initial release
// ============================================================================
interface md_if;
  logic [31:0] Ins;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic [31:0] MDResult;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  // CPU side drives the instruction and register operands
  modport master (
    output Ins, Rdata1, Rdata2,
    input  MDResult, Busy, Stall, HI, LO
  );

  // Multiply/divide unit side
  modport slave (
    input  Ins, Rdata1, Rdata2,
    output MDResult, Busy, Stall, HI, LO
  );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Iterative multiply/divide unit owning HI/LO. Executes
//                MULT/MULTU (shift-add) and DIV/DIVU (restoring) one bit per
//                cycle, plus single-cycle MFHI/MFLO/MTHI/MTLO.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
  parameter int ITERS = 32
) (
  input  wire logic CLK,
  input  wire logic RST,
  md_if.slave       bus
);

  localparam int CW = $clog2(ITERS);

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          state_q;
  logic            busy_q;
  logic [CW-1:0]   count_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic [63:0]     acc_q;     // product accumulator, or {remainder, dividend/quotient}
  logic [63:0]     mcand_q;   // multiplicand, shifted left each step
  logic [31:0]     b_q;       // multiplier (shifted right) or divisor (held)
  logic            is_div_q;
  logic            neg_q;     // product / quotient must be negated
  logic            rneg_q;    // remainder must be negated
  logic            dz_q;      // divisor was zero
  logic [31:0]     rs_q;      // raw rs, returned in HI on divide by zero

  // Instruction decode
  logic        special;
  logic [5:0]  funct;
  logic        op_mfhi, op_mthi, op_mflo, op_mtlo;
  logic        op_mul, op_div, op_signed, op_any;

  always_comb begin
    special   = (bus.Ins[31:26] == 6'd0);
    funct     = bus.Ins[5:0];
    op_mfhi   = special && (funct == FN_MFHI);
    op_mthi   = special && (funct == FN_MTHI);
    op_mflo   = special && (funct == FN_MFLO);
    op_mtlo   = special && (funct == FN_MTLO);
    op_mul    = special && ((funct == FN_MULT) || (funct == FN_MULTU));
    op_div    = special && ((funct == FN_DIV)  || (funct == FN_DIVU));
    op_signed = special && ((funct == FN_MULT) || (funct == FN_DIV));
    op_any    = op_mfhi || op_mthi || op_mflo || op_mtlo || op_mul || op_div;
  end

  // Operand magnitudes and signs captured at issue
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    sign_a = op_signed && bus.Rdata1[31];
    sign_b = op_signed && bus.Rdata2[31];
    mag_a  = sign_a ? (32'd0 - bus.Rdata1) : bus.Rdata1;
    mag_b  = sign_b ? (32'd0 - bus.Rdata2) : bus.Rdata2;
  end

  // One iteration of shift-add multiply or restoring divide, plus final fix-up
  logic [63:0] acc_d;
  logic [63:0] mul_acc;
  logic [63:0] div_acc;
  logic [32:0] rem_sh;
  logic [32:0] rem_sub;
  logic [63:0] prod;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  always_comb begin
    mul_acc = acc_q + (b_q[0] ? mcand_q : 64'd0);
    // Bring the next dividend bit into the partial remainder; a borrow out of
    // bit 32 means the divisor did not fit and the remainder is restored.
    rem_sh  = {acc_q[63:32], acc_q[31]};
    rem_sub = rem_sh - {1'b0, b_q};
    if (!rem_sub[32]) begin
      div_acc = {rem_sub[31:0], acc_q[30:0], 1'b1};
    end else begin
      div_acc = {rem_sh[31:0], acc_q[30:0], 1'b0};
    end
    acc_d = is_div_q ? div_acc : mul_acc;

    prod = neg_q ? (64'd0 - acc_d) : acc_d;
    if (!is_div_q) begin
      hi_d = prod[63:32];
      lo_d = prod[31:0];
    end else if (dz_q) begin
      hi_d = rs_q;
      lo_d = 32'hFFFF_FFFF;
    end else begin
      hi_d = rneg_q ? (32'd0 - acc_d[63:32]) : acc_d[63:32];
      lo_d = neg_q  ? (32'd0 - acc_d[31:0])  : acc_d[31:0];
    end
  end

  // Control FSM, iteration datapath and HI/LO ownership
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      count_q  <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      b_q      <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      rs_q     <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_mul || op_div) begin
            acc_q    <= op_div ? {32'd0, mag_a} : 64'd0;
            mcand_q  <= {32'd0, mag_a};
            b_q      <= mag_b;
            is_div_q <= op_div;
            neg_q    <= sign_a ^ sign_b;
            rneg_q   <= sign_a;
            dz_q     <= (bus.Rdata2 == 32'd0);
            rs_q     <= bus.Rdata1;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            if (op_mthi) hi_q <= bus.Rdata1;
            if (op_mtlo) lo_q <= bus.Rdata1;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          mcand_q <= {mcand_q[62:0], 1'b0};
          if (!is_div_q) b_q <= {1'b0, b_q[31:1]};
          count_q <= count_q + 1'b1;
          if (count_q == CW'(ITERS - 1)) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read-back mux and dependency stall
  always_comb begin
    bus.MDResult = op_mfhi ? hi_q : (op_mflo ? lo_q : 32'd0);
    bus.Stall    = busy_q && op_any;
    bus.Busy     = busy_q;
    bus.HI       = hi_q;
    bus.LO       = lo_q;
  end

endmodule
`default_nettype wire
